// File: rtl/t07_cpu_mem_request_unit.sv
// Memory request unit between the execute stage and the external bus.
// Sizes and steers load/store data, holds the bus request, freezes the CPU.
module t07_cpu_mem_request_unit #(
    parameter int NUM_SRC     = 2,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  memWrite,
    input  logic                  memRead,
    input  logic [SRC_W-1:0]      memSource,
    input  logic [1:0]            memSize,
    input  logic                  memSigned,
    input  logic [ADDR_W-1:0]     ALU_address,
    input  logic [NUM_SRC*32-1:0] src_data,
    input  logic [31:0]           ExtData,
    input  logic                  ExtAck,
    output logic [ADDR_W-1:0]     ExtAddress,
    output logic [31:0]           write_data,
    output logic [3:0]            byte_en,
    output logic [1:0]            rwi,
    output logic [31:0]           dataToCPU,
    output logic                  freeze,
    output logic                  misaligned,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wd_q, wd_d;
    logic [3:0]          be_q, be_d;
    logic [1:0]          rwi_q, rwi_d;
    logic [1:0]          size_q, size_d;
    logic                sgn_q, sgn_d;
    logic [1:0]          off_q, off_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [31:0]         dout_q, dout_d;
    logic                mis_q, mis_d;
    logic                terr_q, terr_d;

    logic [31:0] src_sel;
    logic [31:0] wd_n;
    logic [3:0]  be_n;
    logic [31:0] ld_sh;
    logic [31:0] ld_val;
    logic        req_v;
    logic        is_mis;

    always_comb begin
        src_sel = src_data[31:0];
        for (int k = 1; k < NUM_SRC; k++) begin
            if (int'(memSource) == k) src_sel = src_data[k*32 +: 32];
        end
    end

    always_comb begin
        case (memSize)
            2'b00: begin
                be_n = 4'b0001 << ALU_address[1:0];
                wd_n = {4{src_sel[7:0]}};
            end
            2'b01: begin
                be_n = 4'b0011 << ALU_address[1:0];
                wd_n = {2{src_sel[15:0]}};
            end
            default: begin
                be_n = 4'b1111;
                wd_n = src_sel;
            end
        endcase
    end

    assign req_v  = memRead | memWrite;
    assign is_mis = ((memSize == 2'b01) & ALU_address[0])
                  | (memSize[1] & (|ALU_address[1:0]));

    // Loads use the lane offset and size captured at request time.
    assign ld_sh = ExtData >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   ld_val = {{24{sgn_q & ld_sh[7]}}, ld_sh[7:0]};
            2'b01:   ld_val = {{16{sgn_q & ld_sh[15]}}, ld_sh[15:0]};
            default: ld_val = ld_sh;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        be_d    = be_q;
        rwi_d   = rwi_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        off_d   = off_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        mis_d   = 1'b0;
        terr_d  = 1'b0;
        freeze  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_v && is_mis) begin
                    mis_d = 1'b1;
                end else if (req_v) begin
                    freeze  = 1'b1;
                    state_d = REQ;
                    addr_d  = {ALU_address[ADDR_W-1:2], 2'b00};
                    wd_d    = wd_n;
                    be_d    = be_n;
                    rwi_d   = memWrite ? 2'b01 : 2'b10;
                    size_d  = memSize;
                    sgn_d   = memSigned;
                    off_d   = ALU_address[1:0];
                    cnt_d   = '0;
                end
            end
            REQ: begin
                freeze = 1'b1;
                if (ExtAck || cnt_q == TO_LAST) begin
                    state_d = DONE;
                    addr_d  = '0;
                    wd_d    = '0;
                    be_d    = '0;
                    rwi_d   = '0;
                    // Ack wins over a coincident timeout.
                    if (ExtAck) begin
                        if (rwi_q == 2'b10) dout_d = ld_val;
                    end else begin
                        if (rwi_q == 2'b10) dout_d = '0;
                        terr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wd_q    <= '0;
            be_q    <= '0;
            rwi_q   <= '0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            off_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            mis_q   <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            be_q    <= be_d;
            rwi_q   <= rwi_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            off_q   <= off_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            mis_q   <= mis_d;
            terr_q  <= terr_d;
        end
    end

    assign ExtAddress  = addr_q;
    assign write_data  = wd_q;
    assign byte_en     = be_q;
    assign rwi         = rwi_q;
    assign dataToCPU   = dout_q;
    assign misaligned  = mis_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_t07_cpu_mem_request_unit.sv
// Scoreboard bench for t07_cpu_mem_request_unit.
// Stimulus pushes expected bus requests and completions; a monitor checks them.
module tb_t07_cpu_mem_request_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        memWrite, memRead;
    logic [0:0]  memSource;
    logic [1:0]  memSize;
    logic        memSigned;
    logic [31:0] ALU_address;
    logic [63:0] src_data;
    logic [31:0] ExtData;
    logic        ExtAck;
    logic [31:0] ExtAddress, write_data, dataToCPU;
    logic [3:0]  byte_en;
    logic [1:0]  rwi;
    logic        freeze, misaligned, timeout_err;

    always #5 clk = ~clk;

    t07_cpu_mem_request_unit #(
        .NUM_SRC(2), .ADDR_W(32), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .memWrite(memWrite), .memRead(memRead),
        .memSource(memSource), .memSize(memSize),
        .memSigned(memSigned), .ALU_address(ALU_address),
        .src_data(src_data), .ExtData(ExtData), .ExtAck(ExtAck),
        .ExtAddress(ExtAddress), .write_data(write_data),
        .byte_en(byte_en), .rwi(rwi), .dataToCPU(dataToCPU),
        .freeze(freeze), .misaligned(misaligned),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [1:0]  rwi;
        bit          chk_wd;
    } req_t;

    typedef struct {
        logic [31:0] dout;
        logic        terr;
        int          fcyc;
    } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int    exp_mis = 0;
    int    checks  = 0;
    int    passes  = 0;
    bit    mon_en  = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic evt_fail(string nm);
        checks++;
        $display("FAIL %s: unexpected event, got 1 expected 0", nm);
    endtask

    logic [1:0] prwi = '0;
    logic       pfrz = 1'b0;
    int         fc   = 0;
    req_t       mr;
    done_t      md;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rwi != 2'b00 && prwi == 2'b00) begin
                if (req_q.size() == 0) evt_fail("req_start");
                else begin
                    mr = req_q.pop_front();
                    chk("ExtAddress", ExtAddress, mr.addr);
                    if (mr.chk_wd) chk("write_data", write_data, mr.wd);
                    chk("byte_en", 32'(byte_en), 32'(mr.be));
                    chk("rwi", 32'(rwi), 32'(mr.rwi));
                end
            end
            if (freeze) fc++;
            else if (pfrz) begin
                if (done_q.size() == 0) evt_fail("done");
                else begin
                    md = done_q.pop_front();
                    chk("dataToCPU", dataToCPU, md.dout);
                    chk("timeout_err", 32'(timeout_err), 32'(md.terr));
                    chk("freeze_cycles", fc, md.fcyc);
                end
                fc = 0;
            end
            if (misaligned) begin
                if (exp_mis == 0) evt_fail("misaligned");
                else begin
                    exp_mis--;
                    chk("mis_freeze", 32'(freeze), 32'd0);
                    chk("mis_rwi", 32'(rwi), 32'd0);
                end
            end
            prwi = rwi;
            pfrz = freeze;
        end
    end

    task automatic clear_req();
        memWrite    = 1'b0;
        memRead     = 1'b0;
        memSource   = '0;
        memSize     = 2'b00;
        memSigned   = 1'b0;
        ALU_address = '0;
    endtask

    task automatic txn(bit wr, bit rd, logic [0:0] src, logic [1:0] sz,
                       bit sg, logic [31:0] a, logic [31:0] ed,
                       int ack_at, bit ack, logic [31:0] e_wd,
                       logic [3:0] e_be, logic [31:0] e_dout, bit e_terr);
        req_t  r;
        done_t d;
        r.addr   = {a[31:2], 2'b00};
        r.wd     = e_wd;
        r.be     = e_be;
        r.rwi    = wr ? 2'b01 : 2'b10;
        r.chk_wd = wr;
        d.dout   = e_dout;
        d.terr   = e_terr;
        d.fcyc   = ack_at + 1;
        req_q.push_back(r);
        done_q.push_back(d);
        @(posedge clk); #1;
        memWrite    = wr;
        memRead     = rd;
        memSource   = src;
        memSize     = sz;
        memSigned   = sg;
        ALU_address = a;
        ExtData     = ed;
        for (int c = 1; c <= ack_at; c++) begin
            @(posedge clk); #1;
            ExtAck = ack && (c == ack_at);
        end
        @(posedge clk); #1;
        ExtAck = 1'b0;
    endtask

    task automatic mis(logic [1:0] sz, logic [31:0] a, int hold);
        exp_mis += hold;
        @(posedge clk); #1;
        memRead     = 1'b1;
        memSize     = sz;
        ALU_address = a;
        repeat (hold - 1) @(posedge clk);
        @(posedge clk); #1;
        clear_req();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        ExtAck   = 1'b0;
        ExtData  = '0;
        src_data = {32'h12345678, 32'h87654321};
        clear_req();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ExtAddress", ExtAddress, 32'd0);
        chk("rst_write_data", write_data, 32'd0);
        chk("rst_byte_en", 32'(byte_en), 32'd0);
        chk("rst_rwi", 32'(rwi), 32'd0);
        chk("rst_dataToCPU", dataToCPU, 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        @(posedge clk); #1;
        rst    = 1'b0;
        mon_en = 1'b1;

        txn(0, 1, 0, 2'b10, 0, 32'h4, 32'h99999999, 1, 1,
            32'h0, 4'b1111, 32'h99999999, 0);
        txn(1, 0, 1, 2'b10, 0, 32'h10, 32'h0, 1, 1,
            32'h12345678, 4'b1111, 32'h99999999, 0);
        txn(1, 0, 0, 2'b00, 0, 32'h7, 32'h0, 1, 1,
            32'h21212121, 4'b1000, 32'h99999999, 0);
        txn(1, 0, 0, 2'b01, 0, 32'h2, 32'h0, 2, 1,
            32'h43214321, 4'b1100, 32'h99999999, 0);
        txn(1, 1, 1, 2'b11, 0, 32'h20, 32'h0, 1, 1,
            32'h12345678, 4'b1111, 32'h99999999, 0);
        txn(0, 1, 0, 2'b01, 1, 32'h2, 32'h80F07F01, 1, 1,
            32'h0, 4'b1100, 32'hFFFF80F0, 0);
        txn(0, 1, 0, 2'b00, 0, 32'h1, 32'h80F07F01, 3, 1,
            32'h0, 4'b0010, 32'h0000007F, 0);
        txn(0, 1, 0, 2'b00, 1, 32'h3, 32'h80F07F01, 1, 1,
            32'h0, 4'b1000, 32'hFFFFFF80, 0);

        mis(2'b10, 32'h6, 1);
        mis(2'b01, 32'h3, 2);

        txn(0, 1, 0, 2'b10, 0, 32'h8, 32'h55555555, TO, 0,
            32'h0, 4'b1111, 32'h0, 1);
        txn(0, 1, 0, 2'b10, 0, 32'hC, 32'hCAFEF00D, TO, 1,
            32'h0, 4'b1111, 32'hCAFEF00D, 0);

        req_q.push_back('{32'h40, 32'h0, 4'b1111, 2'b10, 1'b0});
        done_q.push_back('{32'h0, 1'b0, 3});
        @(posedge clk); #1;
        memRead     = 1'b1;
        memSize     = 2'b10;
        ALU_address = 32'h40;
        ExtData     = 32'hFFFFFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_req();
        @(negedge clk);
        chk("rstreq_ExtAddress", ExtAddress, 32'd0);
        chk("rstreq_byte_en", 32'(byte_en), 32'd0);
        chk("rstreq_rwi", 32'(rwi), 32'd0);
        chk("rstreq_dataToCPU", dataToCPU, 32'd0);
        @(posedge clk); #1;
        ExtAck = 1'b1;
        @(posedge clk); #1;
        ExtAck = 1'b0;
        @(negedge clk);
        chk("late_ack_dataToCPU", dataToCPU, 32'd0);
        chk("late_ack_rwi", 32'(rwi), 32'd0);
        chk("late_ack_freeze", 32'(freeze), 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("req_q_left", req_q.size(), 32'd0);
        chk("done_q_left", done_q.size(), 32'd0);
        chk("mis_left", exp_mis, 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
